dmem_responder: RTL
===================

DMEM_RESPONDER -- requirements
Module: dmem_responder

Interface
REQ-001 Parameter DEPTH_WORDS, default 4096, SHALL set the number of 32-bit words in the backing array (power of two, 16..65536).
REQ-002 Parameter LATENCY, default 2, SHALL set the busy cycles per access (legal 1..15).
REQ-003 Parameter TOHOST_ADDR, default 32'h0001_0000, SHALL set the word-aligned byte address of the host-mailbox register.
REQ-004 clk_i  input  1  single clock; all state changes on its rising edge.
REQ-005 rst_i  input  1  synchronous, active-high reset.
REQ-006 dm_en_i  input  1  access request from the core.
REQ-007 dm_wen_i  input  1  1 = write, 0 = read; qualified by dm_en_i.
REQ-008 dm_addr_i  input  32  byte address; bits [1:0] ignored.
REQ-009 dm_din_i  input  32  write data.
REQ-010 dm_dout_o  output  32  read data.
REQ-011 dm_busy_o  output  1  access in progress; registered.
REQ-012 err_o  output  1  one-cycle pulse: completed access was out of range.
REQ-013 tohost_o  output  32  last value written to TOHOST_ADDR.
REQ-014 tohost_valid_o  output  1  sticky: TOHOST_ADDR has been written since reset.

Function
REQ-015 FSM SHALL have two states: IDLE (dm_busy_o=0) and BUSY (dm_busy_o=1), plus a 4-bit down-counter.
REQ-016 A request SHALL be accepted on an edge where dm_en_i=1 and the FSM is in IDLE; addr[31:2], wen and din are latched, the counter is loaded with LATENCY-1, and the FSM enters BUSY.
REQ-017 In BUSY, dm_en_i and all request inputs SHALL be ignored; the counter decrements each cycle.
REQ-018 On the edge where the counter is 0 in BUSY, the access SHALL complete: the FSM returns to IDLE, giving exactly LATENCY cycles of dm_busy_o=1 after the acceptance edge.
REQ-019 Write commit (array or mailbox) SHALL occur on the completion edge only, using the latched address/data.
REQ-020 Read: dm_dout_o SHALL update on the completion edge with the array word at the latched address, and SHALL hold until the next read completes; writes SHALL NOT change dm_dout_o.
REQ-021 Word index = latched addr[31:2]; in range when index < DEPTH_WORDS.
REQ-022 Write to TOHOST_ADDR SHALL load tohost_o, set tohost_valid_o, and leave the array untouched; this takes priority over range decoding.
REQ-023 Read of TOHOST_ADDR SHALL return tohost_o.
REQ-024 Out-of-range read SHALL return 32'h0; out-of-range write SHALL be dropped; both SHALL pulse err_o high for the one cycle after the completion edge.
REQ-025 A new request presented in the first IDLE cycle after completion SHALL be accepted on that edge, with no dead cycle (back-to-back throughput = one access per LATENCY+1 cycles).
REQ-026 A read following a write to the same address SHALL return the newly written data.
REQ-027 dm_en_i=1 in IDLE with undefined-free inputs SHALL always be accepted; there is no back-pressure beyond dm_busy_o.

Reset
REQ-028 While rst_i=1 at an edge: FSM=IDLE, counter=0, dm_busy_o=0, dm_dout_o=0, err_o=0, tohost_o=0, tohost_valid_o=0.
REQ-029 Reset during BUSY SHALL abort the access: no array/mailbox write, dm_dout_o forced to 0.
REQ-030 Array contents SHALL NOT be cleared by reset; a request with dm_en_i=1 while rst_i=1 SHALL be ignored.

Verification
REQ-031 LATENCY=2: write 32'hDEAD_BEEF to 0x40, then read 0x40 -> busy high exactly 2 cycles per access, dm_dout_o=32'hDEAD_BEEF after read completion, err_o never pulses.
REQ-032 Back-to-back: reads of 0x0, 0x4, 0x8 (preloaded 1,2,3) with dm_en_i held high -> acceptances every 3 cycles, dm_dout_o steps 1,2,3, no dead cycle.
REQ-033 Write 32'h0000_0001 to 0x0001_0000 -> tohost_o=1, tohost_valid_o=1 after completion; array word 0 unchanged; read of 0x0001_0000 returns 1.
REQ-034 DEPTH_WORDS=4096: read 0x0000_4000 -> dm_dout_o=0, err_o high one cycle; write there -> dropped, err_o pulses.
REQ-035 Write 32'h1234_5678 to 0x10, assert rst_i mid-BUSY -> busy drops next edge, dm_dout_o=0, later read of 0x10 returns prior contents (not 32'h1234_5678).
REQ-036 LATENCY=1 and LATENCY=15 sweeps: busy width equals LATENCY; dm_en_i toggling during BUSY has no effect.

Source files
------------

// File: rtl/dmem_if.sv
// Data-memory request/response bundle between the core and the responder.
// The master drives the request; the slave returns data, status and mailbox.
interface dmem_if;
  logic        dm_en;
  logic        dm_wen;
  logic [31:0] dm_addr;
  logic [31:0] dm_din;
  logic [31:0] dm_dout;
  logic        dm_busy;
  logic        err;
  logic [31:0] tohost;
  logic        tohost_valid;

  modport master (
    output dm_en, dm_wen, dm_addr, dm_din,
    input  dm_dout, dm_busy, err, tohost, tohost_valid
  );

  modport slave (
    input  dm_en, dm_wen, dm_addr, dm_din,
    output dm_dout, dm_busy, err, tohost, tohost_valid
  );
endinterface

// File: rtl/dmem_responder.sv
// Fixed-latency data-memory responder with word array and host mailbox.
// One access at a time; completion commits writes or updates read data.
module dmem_responder #(
  parameter int unsigned DEPTH_WORDS = 4096,
  parameter int unsigned LATENCY     = 2,
  parameter logic [31:0] TOHOST_ADDR = 32'h0001_0000
) (
  input logic   clk_i,
  input logic   rst_i,
  dmem_if.slave dm
);
  localparam int AW = $clog2(DEPTH_WORDS);
  localparam logic [3:0] CNT_LOAD = 4'(LATENCY - 1);

  typedef enum logic {IDLE, BUSY} state_t;

  state_t      state;
  logic [3:0]  cnt;
  logic [29:0] idx_q;
  logic        wen_q;
  logic [31:0] din_q;
  logic        busy_q;
  logic [31:0] dout_q;
  logic        err_q;
  logic [31:0] tohost_q;
  logic        tohost_vld_q;

  logic [31:0] mem [DEPTH_WORDS];

  logic done;
  logic hit_host;
  logic in_range;
  logic unused_ok;

  assign done     = (state == BUSY) && (cnt == 4'd0);
  assign hit_host = idx_q == TOHOST_ADDR[31:2];
  assign in_range = idx_q < 30'(DEPTH_WORDS);
  assign unused_ok = &{1'b0, dm.dm_addr[1:0]};

  assign dm.dm_busy      = busy_q;
  assign dm.dm_dout      = dout_q;
  assign dm.err          = err_q;
  assign dm.tohost       = tohost_q;
  assign dm.tohost_valid = tohost_vld_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state        <= IDLE;
      cnt          <= 4'd0;
      idx_q        <= 30'd0;
      wen_q        <= 1'b0;
      din_q        <= 32'd0;
      busy_q       <= 1'b0;
      dout_q       <= 32'd0;
      err_q        <= 1'b0;
      tohost_q     <= 32'd0;
      tohost_vld_q <= 1'b0;
    end else begin
      err_q <= 1'b0;
      unique case (state)
        IDLE: begin
          if (dm.dm_en) begin
            state  <= BUSY;
            cnt    <= CNT_LOAD;
            idx_q  <= dm.dm_addr[31:2];
            wen_q  <= dm.dm_wen;
            din_q  <= dm.dm_din;
            busy_q <= 1'b1;
          end
        end
        BUSY: begin
          if (cnt == 4'd0) begin
            state  <= IDLE;
            busy_q <= 1'b0;
            // mailbox decode wins over the range check
            if (hit_host) begin
              if (wen_q) begin
                tohost_q     <= din_q;
                tohost_vld_q <= 1'b1;
              end else begin
                dout_q <= tohost_q;
              end
            end else if (!in_range) begin
              err_q <= 1'b1;
              if (!wen_q) dout_q <= 32'd0;
            end else if (!wen_q) begin
              dout_q <= mem[idx_q[AW-1:0]];
            end
          end else begin
            cnt <= cnt - 4'd1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Array is never cleared; reset only suppresses a pending commit.
  always_ff @(posedge clk_i) begin
    if (!rst_i && done && wen_q && !hit_host && in_range)
      mem[idx_q[AW-1:0]] <= din_q;
  end
endmodule
